// File: rtl/fns_pkg.sv
// Shared definitions for the FNS (Zeckendorf) encoder controller.
//   fns_state_e  : controller state encoding
//   fns_wgt_w    : weight/residue width for a given data width
//   fns_max_code : largest value representable in a code_w-bit codeword
package fns_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_ENC  = 2'd2,
    ST_DONE = 2'd3
  } fns_state_e;

  // One extra bit so any weight above the largest input compares greater.
  function automatic int unsigned fns_wgt_w(input int unsigned data_w);
    return data_w + 1;
  endfunction

  // w0=1, w1=2, wk=wk-1+wk-2; the limit is w_code_w - 1.
  function automatic int unsigned fns_max_code(input int unsigned code_w);
    int unsigned a;
    int unsigned b;
    int unsigned t;
    a = 1;
    b = 2;
    for (int unsigned k = 2; k <= code_w; k++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return b - 1;
  endfunction

endpackage

// File: rtl/fns_enc_ctrl_if.sv
// Handshake bundle between the data source, the encoder and the wire driver.
//   in_valid/in_ready/in_data            : binary word into the encoder
//   out_valid/out_ready/out_code/out_ovf : FNS codeword out of the encoder
//   master : source/sink side, slave : encoder side
interface fns_enc_ctrl_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CODE_W = 12
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CODE_W-1:0] out_code;
  logic              out_ovf;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_code, out_ovf
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_code, out_ovf
  );
endinterface

// File: rtl/fns_greedy_step.sv
// One MSB-first greedy Zeckendorf step (combinational).
//   res_i  : current residue        wk_i : weight of the current bit
//   skip_i : previous bit was set, so this bit is forced to 0
//   bit_c  : resolved code bit      res_c/skip_c : residue and skip for next bit
module fns_greedy_step #(
  parameter int unsigned W = 9
) (
  input  logic [W-1:0] res_i,
  input  logic [W-1:0] wk_i,
  input  logic         skip_i,
  output logic         bit_c,
  output logic [W-1:0] res_c,
  output logic         skip_c
);

  // A set bit always forces the next lower bit to 0, so "11" cannot appear.
  always_comb begin
    bit_c  = 1'b0;
    res_c  = res_i;
    skip_c = 1'b0;
    if (!skip_i && (res_i >= wk_i)) begin
      bit_c  = 1'b1;
      res_c  = res_i - wk_i;
      skip_c = 1'b1;
    end
  end

endmodule

// File: rtl/fns_enc_ctrl.sv
// Binary -> Fibonacci-numeral-system (Zeckendorf) encoder controller.
// Builds the weight table after reset (INIT), then encodes one word per
// request MSB first, one bit per cycle, with valid/ready on both sides.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fns_enc_ctrl_if.slave (input word / output codeword handshakes)
//   busy       : controller not in IDLE
// Optional: FNS_ENC_OVF_CHECK_EN enables out_ovf and zeroes out_code on overflow.
module fns_enc_ctrl
  import fns_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CODE_W = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  fns_enc_ctrl_if.slave   bus,
  output logic            busy
);

  localparam int unsigned   WGT_W = fns_wgt_w(DATA_W);
  localparam int unsigned   KW    = $clog2(CODE_W);
  localparam logic [KW-1:0] K_TOP = KW'(CODE_W - 1);

  fns_state_e        state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [WGT_W-1:0]  res_q, res_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [CODE_W-1:0] out_code_q, out_code_d;
  logic              skip_q, skip_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;
  logic [WGT_W-1:0]  wgt_q [CODE_W];
  logic [WGT_W-1:0]  wgt_d [CODE_W];
`ifdef FNS_ENC_OVF_CHECK_EN
  logic              out_ovf_q, out_ovf_d;
`endif

  logic [WGT_W:0]    wsum;
  logic [WGT_W-1:0]  wsat;
  logic              step_bit;
  logic [WGT_W-1:0]  step_res;
  logic              step_skip;

  // Shared weight adder: wk = wk-1 + wk-2, sticky saturation at all-ones.
  assign wsum = {1'b0, wgt_q[k_q - KW'(1)]} + {1'b0, wgt_q[k_q - KW'(2)]};
  assign wsat = wsum[WGT_W] ? '1 : wsum[WGT_W-1:0];

  fns_greedy_step #(.W(WGT_W)) u_step (
    .res_i  (res_q),
    .wk_i   (wgt_q[k_q]),
    .skip_i (skip_q),
    .bit_c  (step_bit),
    .res_c  (step_res),
    .skip_c (step_skip)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      k_q         <= KW'(2);
      res_q       <= '0;
      code_q      <= '0;
      skip_q      <= 1'b0;
      out_code_q  <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b1;
      for (int unsigned i = 0; i < CODE_W; i++) begin
        wgt_q[i] <= WGT_W'(i == 0 ? 1 : (i == 1 ? 2 : 0));
      end
`ifdef FNS_ENC_OVF_CHECK_EN
      out_ovf_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      res_q       <= res_d;
      code_q      <= code_d;
      skip_q      <= skip_d;
      out_code_q  <= out_code_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      wgt_q       <= wgt_d;
`ifdef FNS_ENC_OVF_CHECK_EN
      out_ovf_q   <= out_ovf_d;
`endif
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    res_d      = res_q;
    code_d     = code_q;
    skip_d     = skip_q;
    out_code_d = out_code_q;
    wgt_d      = wgt_q;
`ifdef FNS_ENC_OVF_CHECK_EN
    out_ovf_d  = out_ovf_q;
`endif

    case (state_q)
      ST_INIT: begin
        wgt_d[k_q] = wsat;
        if (k_q == K_TOP) begin
          state_d = ST_IDLE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      ST_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          res_d   = WGT_W'(bus.in_data);
          code_d  = '0;
          k_d     = K_TOP;
          skip_d  = 1'b0;
          state_d = ST_ENC;
        end
      end
      ST_ENC: begin
        code_d[k_q] = step_bit;
        res_d       = step_res;
        skip_d      = step_skip;
        if (k_q == '0) begin
          state_d    = ST_DONE;
          out_code_d = code_d;
`ifdef FNS_ENC_OVF_CHECK_EN
          // Leftover residue means the word exceeds the codeword range.
          out_ovf_d  = (step_res != '0);
          if (step_res != '0) begin
            out_code_d = '0;
          end
`endif
        end else begin
          k_d = k_q - KW'(1);
        end
      end
      ST_DONE: begin
        if (out_valid_q && bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_INIT;
    endcase

    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_code  = out_code_q;
  assign busy          = busy_q;
`ifdef FNS_ENC_OVF_CHECK_EN
  assign bus.out_ovf   = out_ovf_q;
`else
  assign bus.out_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_fns_enc_ctrl.sv
// Directed bench for fns_enc_ctrl: default instance (DATA_W=8) plus a
// DATA_W=9 instance for the overflow case. Expected values are hand-derived.
module tb_fns_enc_ctrl;
  import fns_pkg::*;

  logic clk;
  logic rst_n;
  logic busy;
  logic busy9;
  int   tests;
  int   fails;

  fns_enc_ctrl_if #(.DATA_W(8), .CODE_W(12)) bus  ();
  fns_enc_ctrl_if #(.DATA_W(9), .CODE_W(12)) bus9 ();

  fns_enc_ctrl #(.DATA_W(8), .CODE_W(12)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  fns_enc_ctrl #(.DATA_W(9), .CODE_W(12)) dut9 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus9),
    .busy  (busy9)
  );

`ifdef FNS_ENC_OVF_CHECK_EN
  localparam logic [11:0] EXP9_CODE = 12'h000;
  localparam logic        EXP9_OVF  = 1'b1;
`else
  // 400 greedy: 233+89+34+13+5+2 = 376, residue 24 discarded.
  localparam logic [11:0] EXP9_CODE = 12'hAAA;
  localparam logic        EXP9_OVF  = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Accept a word (caller leaves in_ready=1), wait for the codeword, check it,
  // optionally hold backpressure, then release.
  task automatic encode(input logic [7:0] val, input logic [11:0] exp_code,
                        input int hold, input string tag);
    int n;
    logic [11:0] c;
    bus.in_data  = val;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = ~val;
    chk($sformatf("%s_inrdy_enc", tag), 32'(bus.in_ready), 32'd0);
    n = 0;
    while (!bus.out_valid && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("%s_latency", tag), 32'(n), 32'd12);
    chk($sformatf("%s_code", tag), 32'(bus.out_code), 32'(exp_code));
    chk($sformatf("%s_ovf", tag), 32'(bus.out_ovf), 32'd0);
    c = bus.out_code;
    chk($sformatf("%s_no11", tag), 32'(c & (c >> 1)), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk($sformatf("%s_hold%0d", tag, i),
          32'({bus.out_valid, bus.in_ready, bus.out_code}), 32'({1'b1, 1'b0, exp_code}));
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk($sformatf("%s_ovalid_drop", tag), 32'(bus.out_valid), 32'd0);
    chk($sformatf("%s_inrdy_back", tag), 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int n;
    int rdy_at;
    int saw_valid;
    int unsigned w_exp [12] = '{1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233};
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b0;
    bus9.in_valid  = 1'b0;
    bus9.in_data   = '0;
    bus9.out_ready = 1'b0;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_code", 32'(bus.out_code), 32'd0);
    chk("rst_out_ovf", 32'(bus.out_ovf), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_w0", 32'(dut.wgt_q[0]), 32'd1);
    chk("rst_w1", 32'(dut.wgt_q[1]), 32'd2);
    chk("rst_w2", 32'(dut.wgt_q[2]), 32'd0);

    // INIT takes exactly 10 cycles.
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      chk($sformatf("init_rdy_c%0d", i), 32'(bus.in_ready), (i == 10) ? 32'd1 : 32'd0);
    end
    chk("init_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("w%0d", i), 32'(dut.wgt_q[i]), w_exp[i]);
    end

    // Encodings.
    encode(8'd0,   12'h000, 0,  "d0");
    encode(8'd100, 12'h214, 0,  "d100");
    encode(8'd255, 12'h841, 0,  "d255");
    encode(8'd7,   12'h00A, 20, "d7_bp");

    // Wider instance: 400 exceeds the 376 limit.
    bus9.in_data  = 9'd400;
    bus9.in_valid = 1'b1;
    @(posedge clk); #1;
    bus9.in_valid = 1'b0;
    n = 0;
    while (!bus9.out_valid && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    chk("d400_latency", 32'(n), 32'd12);
    chk("d400_code", 32'(bus9.out_code), 32'(EXP9_CODE));
    chk("d400_ovf", 32'(bus9.out_ovf), 32'(EXP9_OVF));
    bus9.out_ready = 1'b1;
    @(posedge clk); #1;
    bus9.out_ready = 1'b0;
    chk("d400_release", 32'(bus9.out_valid), 32'd0);

    // Reset during ENC at k=5 drops the word.
    bus.in_data  = 8'd255;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("mid_k", 32'(dut.k_q), 32'd5);
    chk("mid_state", 32'(dut.state_q), 32'(ST_ENC));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_out_code", 32'(bus.out_code), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd1);
    chk("mid_rst_state", 32'(dut.state_q), 32'(ST_INIT));
    @(negedge clk);
    rst_n = 1'b1;
    rdy_at = 0;
    saw_valid = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) saw_valid = 1;
      if (bus.in_ready && rdy_at == 0) rdy_at = i;
    end
    chk("mid_no_valid", 32'(saw_valid), 32'd0);
    chk("mid_rdy_at", 32'(rdy_at), 32'd10);

    // Encoder still works after the aborted word.
    encode(8'd100, 12'h214, 0, "post_d100");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
